// File: rtl/operand_fetch.sv
// operand_fetch: register file plus A/B operand sequencing with a valid/ready handshake to the ALU
module operand_fetch #(
    parameter int DW   = 16,
    parameter int NREG = 8,
    parameter int AW   = 3
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [1:0]    req_op,
    input  logic [AW-1:0] req_rn,
    input  logic [AW-1:0] req_rm,
    input  logic [1:0]    req_shift,
    input  logic          req_asel,
    input  logic          req_bsel,
    input  logic [4:0]    req_imm5,
    input  logic          wb_en,
    input  logic [AW-1:0] wb_reg,
    input  logic [DW-1:0] wb_data,
    output logic [DW-1:0] Ain,
    output logic [DW-1:0] Bin,
    output logic [1:0]    ALUop,
    output logic          out_valid,
    input  logic          out_ready
);
    typedef enum logic [1:0] {IDLE, READ_A, READ_B, PRESENT} state_t;
    state_t state, state_nx;
    logic [DW-1:0] rf [NREG];
    logic [DW-1:0] a_reg, b_reg, rd_data, shifted, imm_sx;
    logic [1:0]    c_op, c_shift;
    logic [AW-1:0] c_rn, c_rm, rd_idx;
    logic          c_asel, c_bsel;
    logic [4:0]    c_imm5;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = (state == IDLE)   ? (req_valid ? READ_A : IDLE) :
                   (state == READ_A) ? READ_B :
                   (state == READ_B) ? PRESENT :
                   (out_ready ? IDLE : PRESENT);
    end

    always_comb begin
        req_ready = state == IDLE;
        out_valid = state == PRESENT;
    end

    // Single read port; a same-cycle write to the read index is forwarded.
    always_comb begin
        rd_idx  = (state == READ_A) ? c_rn : c_rm;
        rd_data = (wb_en && wb_reg == rd_idx) ? wb_data : rf[rd_idx];
        shifted = (c_shift == 2'b01) ? {rd_data[DW-2:0], 1'b0} :
                  (c_shift == 2'b10) ? {1'b0, rd_data[DW-1:1]} :
                  (c_shift == 2'b11) ? {rd_data[DW-1], rd_data[DW-1:1]} : rd_data;
        imm_sx  = {{(DW-5){c_imm5[4]}}, c_imm5};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
            c_op    <= '0;
            c_rn    <= '0;
            c_rm    <= '0;
            c_shift <= '0;
            c_asel  <= 1'b0;
            c_bsel  <= 1'b0;
            c_imm5  <= '0;
        end else begin
            if (wb_en) rf[wb_reg] <= wb_data;
            if (state == IDLE && req_valid) begin
                c_op    <= req_op;
                c_rn    <= req_rn;
                c_rm    <= req_rm;
                c_shift <= req_shift;
                c_asel  <= req_asel;
                c_bsel  <= req_bsel;
                c_imm5  <= req_imm5;
            end
            if (state == READ_A) a_reg <= c_asel ? '0 : rd_data;
            if (state == READ_B) b_reg <= c_bsel ? imm_sx : shifted;
        end
    end

    assign Ain   = a_reg;
    assign Bin   = b_reg;
    assign ALUop = c_op;
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed checks of operand sequencing, shifter, immediate, bypass, backpressure and reset
module tb_operand_fetch;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid, req_ready;
    logic [1:0]  req_op, req_shift;
    logic [2:0]  req_rn, req_rm;
    logic        req_asel, req_bsel;
    logic [4:0]  req_imm5;
    logic        wb_en;
    logic [2:0]  wb_reg;
    logic [15:0] wb_data;
    logic [15:0] Ain, Bin;
    logic [1:0]  ALUop;
    logic        out_valid, out_ready;
    int          n_cmp = 0;
    int          n_err = 0;

    operand_fetch dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_rn(req_rn), .req_rm(req_rm), .req_shift(req_shift),
        .req_asel(req_asel), .req_bsel(req_bsel), .req_imm5(req_imm5),
        .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
        .Ain(Ain), .Bin(Bin), .ALUop(ALUop), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] r, input logic [15:0] d);
        wb_en = 1'b1; wb_reg = r; wb_data = d;
        step();
        wb_en = 1'b0;
    endtask

    // Accept on edge 0; out_ready held low through edge 3, then consumed on edge 4 (+hold cycles).
    task automatic run(input string tag, input logic [2:0] rn, input logic [2:0] rm,
                       input logic [1:0] op, input logic [1:0] sh, input logic asel,
                       input logic bsel, input logic [4:0] imm, input logic bp,
                       input logic [15:0] bp_data, input int hold,
                       input logic [15:0] ea, input logic [15:0] eb);
        out_ready = 1'b0;
        req_valid = 1'b1; req_rn = rn; req_rm = rm; req_op = op; req_shift = sh;
        req_asel = asel; req_bsel = bsel; req_imm5 = imm;
        chk({tag, ".ready_idle"}, {15'd0, req_ready}, 16'd1);
        step();
        req_valid = 1'b0;
        req_rn = ~rn; req_rm = ~rm; req_op = ~op; req_shift = ~sh; req_imm5 = ~imm;
        if (bp) begin
            wb_en = 1'b1; wb_reg = rn; wb_data = bp_data;
        end
        step();
        wb_en = 1'b0;
        chk({tag, ".valid_early"}, {15'd0, out_valid}, 16'd0);
        step();
        step();
        chk({tag, ".valid"}, {15'd0, out_valid}, 16'd1);
        chk({tag, ".ready_busy"}, {15'd0, req_ready}, 16'd0);
        chk({tag, ".Ain"}, Ain, ea);
        chk({tag, ".Bin"}, Bin, eb);
        chk({tag, ".ALUop"}, {14'd0, ALUop}, {14'd0, op});
        for (int i = 0; i < hold; i++) begin
            req_valid = ~req_valid; req_rn = 3'(i); req_rm = 3'(i + 1); req_op = 2'(i);
            req_bsel = ~req_bsel; req_imm5 = 5'(i * 3);
            wb_en = 1'b1; wb_reg = 3'd1; wb_data = 16'h1000 + 16'(i);
            step();
            chk({tag, ".hold_valid"}, {15'd0, out_valid}, 16'd1);
            chk({tag, ".hold_ready"}, {15'd0, req_ready}, 16'd0);
            chk({tag, ".hold_Ain"}, Ain, ea);
            chk({tag, ".hold_Bin"}, Bin, eb);
            chk({tag, ".hold_op"}, {14'd0, ALUop}, {14'd0, op});
        end
        wb_en = 1'b0; req_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, ".consumed"}, {15'd0, out_valid}, 16'd0);
        chk({tag, ".ready_again"}, {15'd0, req_ready}, 16'd1);
    endtask

    initial begin
        reset_n = 1'b0; req_valid = 1'b0; req_op = '0; req_rn = '0; req_rm = '0;
        req_shift = '0; req_asel = 1'b0; req_bsel = 1'b0; req_imm5 = '0;
        wb_en = 1'b0; wb_reg = '0; wb_data = '0; out_ready = 1'b0;
        step();
        step();
        chk("rst.Ain", Ain, 16'h0000);
        chk("rst.Bin", Bin, 16'h0000);
        chk("rst.op", {14'd0, ALUop}, 16'd0);
        chk("rst.valid", {15'd0, out_valid}, 16'd0);
        chk("rst.ready", {15'd0, req_ready}, 16'd1);
        reset_n = 1'b1;
        step();

        wr(3'd1, 16'h0005);
        wr(3'd2, 16'h0003);
        run("basic", 3'd1, 3'd2, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0, 1'b0, 16'h0, 0, 16'h0005, 16'h0003);

        wr(3'd2, 16'h8004);
        run("lsl1", 3'd1, 3'd2, 2'b10, 2'b01, 1'b0, 1'b0, 5'd0, 1'b0, 16'h0, 0, 16'h0005, 16'h0008);
        run("lsr1", 3'd1, 3'd2, 2'b11, 2'b10, 1'b0, 1'b0, 5'd0, 1'b0, 16'h0, 0, 16'h0005, 16'h4002);
        run("asr1", 3'd1, 3'd2, 2'b01, 2'b11, 1'b0, 1'b0, 5'd0, 1'b0, 16'h0, 0, 16'h0005, 16'hC002);

        run("imm_neg", 3'd1, 3'd2, 2'b01, 2'b00, 1'b1, 1'b1, 5'b10000, 1'b0, 16'h0, 0, 16'h0000, 16'hFFF0);
        run("imm_pos", 3'd2, 3'd2, 2'b10, 2'b11, 1'b0, 1'b1, 5'b01111, 1'b0, 16'h0, 0, 16'h8004, 16'h000F);

        wr(3'd3, 16'h0001);
        run("bypass", 3'd3, 3'd2, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0, 1'b1, 16'h00AA, 0, 16'h00AA, 16'h8004);
        run("r3_after", 3'd3, 3'd3, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0, 1'b0, 16'h0, 0, 16'h00AA, 16'h00AA);
        run("bypass_asel", 3'd3, 3'd3, 2'b00, 2'b00, 1'b1, 1'b0, 5'd0, 1'b1, 16'h0055, 0, 16'h0000, 16'h0055);

        run("backpress", 3'd1, 3'd2, 2'b11, 2'b00, 1'b0, 1'b0, 5'd0, 1'b0, 16'h0, 5, 16'h0005, 16'h8004);
        run("after_bp", 3'd1, 3'd1, 2'b01, 2'b00, 1'b0, 1'b0, 5'd0, 1'b0, 16'h0, 0, 16'h1004, 16'h1004);

        // Abort a request during READ_B; writes while in reset must be dropped.
        req_valid = 1'b1; req_rn = 3'd1; req_rm = 3'd2; req_op = 2'b11;
        req_shift = 2'b00; req_asel = 1'b0; req_bsel = 1'b0;
        step();
        req_valid = 1'b0;
        step();
        reset_n = 1'b0;
        wb_en = 1'b1; wb_reg = 3'd1; wb_data = 16'hFFFF;
        #1;
        chk("abort.Ain", Ain, 16'h0000);
        chk("abort.Bin", Bin, 16'h0000);
        chk("abort.op", {14'd0, ALUop}, 16'd0);
        chk("abort.valid", {15'd0, out_valid}, 16'd0);
        chk("abort.ready", {15'd0, req_ready}, 16'd1);
        step();
        wb_en = 1'b0;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("abort.no_valid", {15'd0, out_valid}, 16'd0);
            chk("abort.idle", {15'd0, req_ready}, 16'd1);
        end
        run("post_rst", 3'd1, 3'd2, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0, 1'b0, 16'h0, 0, 16'h0000, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
